serial_complement_ctrl: RTL and testbench
=========================================

SERIAL_COMPLEMENT_CTRL -- requirements
Module: serial_complement_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be legal for 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; SHALL clear all state on negedge reset, independent of clk.
REQ-004 start  input  1  request to begin a conversion; sampled on posedge clk.
REQ-005 mode  input  1  0 = two's complement, 1 = ones' complement; sampled with start.
REQ-006 din  input  WIDTH  operand; sampled with start.
REQ-007 busy  output  1  high while bits are being shifted.
REQ-008 serial_out  output  1  current complemented bit, LSB first.
REQ-009 serial_valid  output  1  qualifies serial_out; equals busy.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 dout  output  WIDTH  complemented result, held until the next accepted start.
REQ-012 ovf  output  1  set with done when mode=0 and din = 1 followed by WIDTH-1 zeros (most negative value); held with dout.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at posedge SHALL load din into shift register, latch mode, clear bit counter and seen_one flag, and move to SHIFT; start=0 stays in IDLE.
REQ-015 start SHALL be ignored in SHIFT and DONE; no queuing, no effect on in-flight data.
REQ-016 SHIFT: each cycle SHALL present one bit, LSB first; the state lasts exactly WIDTH cycles.
REQ-017 mode=1: serial_out SHALL be ~shreg[0].
REQ-018 mode=0: serial_out SHALL be shreg[0] XOR seen_one; seen_one SHALL set at the posedge where shreg[0]=1 and stay set for the rest of the operation.
REQ-019 Each SHIFT posedge SHALL shift shreg right by one, shift serial_out into the result register MSB, and increment the counter.
REQ-020 On the posedge ending the WIDTH-th SHIFT cycle, the FSM SHALL move to DONE and dout/ovf SHALL update to the full result.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 Latency: start sampled at edge E0; busy high from E0 to E(WIDTH); done high from E(WIDTH) to E(WIDTH+1); a new start is accepted at E(WIDTH+1) earliest.
REQ-023 busy and done SHALL never be high in the same cycle; busy SHALL be 0 in IDLE and DONE.
REQ-024 Result arithmetic is modulo 2^WIDTH: din=0, mode=0 gives dout=0 and ovf=0; the most negative value maps to itself with ovf=1.
REQ-025 dout and ovf SHALL NOT change during SHIFT; they hold the previous result until DONE.
REQ-026 Counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-027 While reset=0: state=IDLE, busy=0, done=0, serial_valid=0, serial_out=0, dout=0, ovf=0, and counter, shreg, seen_one and latched mode all 0.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort immediately with no done pulse; the partial result SHALL be discarded.
REQ-029 After reset deasserts, the first posedge SHALL act as normal IDLE; a start held high through deassertion is accepted at that edge.

Verification
REQ-030 WIDTH=8, mode=0, din=0x06 -> serial_out LSB-first 0,1,0,1,1,1,1,1; done at E8; dout=0xFA, ovf=0.
REQ-031 WIDTH=8, mode=1, din=0xA5 -> dout=0x5A at E8, ovf=0; serial_valid high exactly 8 cycles.
REQ-032 WIDTH=8, mode=0, din=0x80 -> dout=0x80, ovf=1; din=0x00 -> dout=0x00, ovf=0.
REQ-033 start pulsed at E3 during SHIFT with din=0xFF -> ignored; first result unchanged; back-to-back start at E9 accepted, done at E17.
REQ-034 reset driven low at E4 of an operation -> busy=0 and dout=0 immediately, no done pulse; next start completes normally.
REQ-035 Random din/mode, 1000 operations -> dout matches (~din + 1) mod 256 for mode 0 and ~din for mode 1; busy/done mutual exclusion holds throughout.

Source files
------------

// File: rtl/serial_complement_if.sv
// serial_complement_if: request/result bundle for serial_complement_ctrl.
interface serial_complement_if #(parameter int WIDTH = 8);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             serial_out;
    logic             serial_valid;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             ovf;
    modport master(output start, mode, din, input busy, serial_out, serial_valid, done, dout, ovf);
    modport slave(input start, mode, din, output busy, serial_out, serial_valid, done, dout, ovf);
endinterface

// File: rtl/serial_complement_ctrl.sv
// serial_complement_ctrl: LSB-first serial two's/ones' complement converter.
module serial_complement_ctrl #(parameter int WIDTH = 8) (
    input logic clk,
    input logic reset,
    serial_complement_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
    logic [1:0]       state;
    logic [WIDTH-1:0] shreg, res, res_next, dout_q;
    logic [CW-1:0]    cnt;
    logic             seen_one, mode_q, ovf_q, bit_out, last;
    assign bit_out = mode_q ? ~shreg[0] : shreg[0] ^ seen_one;
    assign res_next = {bit_out, res[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);
    assign bus.busy = state == SHIFT;
    assign bus.serial_valid = state == SHIFT;
    assign bus.serial_out = (state == SHIFT) & bit_out;
    assign bus.done = state == DONE;
    assign bus.dout = dout_q;
    assign bus.ovf = ovf_q;
    // The edge that closes DONE may already accept the next request, so a
    // back-to-back start costs no idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            res <= '0;
            cnt <= '0;
            seen_one <= 1'b0;
            mode_q <= 1'b0;
            dout_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
            res <= res_next;
            cnt <= cnt + 1'b1;
            seen_one <= seen_one | shreg[0];
            if (last) begin
                state <= DONE;
                dout_q <= res_next;
                ovf_q <= ~mode_q & (res_next == MOST_NEG);
            end
        end else if (bus.start) begin
            state <= SHIFT;
            shreg <= bus.din;
            mode_q <= bus.mode;
            cnt <= '0;
            seen_one <= 1'b0;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_complement_ctrl.sv
// tb_serial_complement_ctrl: randomized self-checking bench against an arithmetic model.
module tb_serial_complement_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] prev_dout = 8'h00;
    logic prev_ovf = 1'b0;

    serial_complement_if #(.WIDTH(8)) bus();
    serial_complement_ctrl #(.WIDTH(8)) dut(.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input logic m);
        int v;
        v = m ? 255 - int'(d) : (256 - int'(d)) % 256;
        return 8'(v);
    endfunction

    // Drives one conversion from a negedge; returns at the negedge of the done
    // cycle (chain=1) or one cycle later in IDLE (chain=0).
    task automatic run_op(input logic [7:0] d, input logic m, input logic inject, input logic chain);
        logic [7:0] exp_d;
        logic exp_o;
        exp_d = model(d, m);
        exp_o = !m && d == 8'h80;
        bus.start = 1'b1;
        bus.din = d;
        bus.mode = m;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.start = inject && i == 2;
            if (inject && i == 2) begin
                bus.din = 8'hFF;
                bus.mode = ~m;
            end
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.serial_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL shift_ctl bit%0d: busy=%b done=%b valid=%b expected 1 0 1", i, bus.busy, bus.done, bus.serial_valid);
            end
            n_checks++;
            if (bus.serial_out !== exp_d[i]) begin
                n_fail++;
                $display("FAIL serial_out din=%h mode=%b bit%0d: got %b expected %b", d, m, i, bus.serial_out, exp_d[i]);
            end
            n_checks++;
            if (bus.dout !== prev_dout || bus.ovf !== prev_ovf) begin
                n_fail++;
                $display("FAIL hold bit%0d: dout=%h ovf=%b expected %h %b", i, bus.dout, bus.ovf, prev_dout, prev_ovf);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ctl din=%h: done=%b busy=%b valid=%b expected 1 0 0", d, bus.done, bus.busy, bus.serial_valid);
        end
        n_checks++;
        if (bus.dout !== exp_d || bus.ovf !== exp_o) begin
            n_fail++;
            $display("FAIL result din=%h mode=%b: dout=%h ovf=%b expected %h %b", d, m, bus.dout, bus.ovf, exp_d, exp_o);
        end
        prev_dout = exp_d;
        prev_ovf = exp_o;
        if (!chain) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.serial_valid !== 1'b0 || bus.serial_out !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ctl: done=%b busy=%b valid=%b sout=%b expected 0 0 0 0", bus.done, bus.busy, bus.serial_valid, bus.serial_out);
            end
            n_checks++;
            if (bus.dout !== prev_dout || bus.ovf !== prev_ovf) begin
                n_fail++;
                $display("FAIL idle_hold: dout=%h ovf=%b expected %h %b", bus.dout, bus.ovf, prev_dout, prev_ovf);
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b1;
        bus.din = 8'h06;
        bus.mode = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.serial_valid !== 1'b0 || bus.serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: busy=%b done=%b valid=%b sout=%b expected 0 0 0 0", bus.busy, bus.done, bus.serial_valid, bus.serial_out);
        end
        n_checks++;
        if (bus.dout !== 8'h00 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_result: dout=%h ovf=%b expected 00 0", bus.dout, bus.ovf);
        end
        reset = 1'b1;
        run_op(8'h06, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ones;
        run_op(8'hA5, 1'b1, 1'b0, 1'b0);
        run_op(8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_boundary;
        run_op(8'h80, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op(8'h06, 1'b0, 1'b1, 1'b1);
        run_op(8'h33, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        bus.start = 1'b1;
        bus.din = 8'h3C;
        bus.mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 8'h00 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b dout=%h ovf=%b expected 0 0 00 0", bus.busy, bus.done, bus.dout, bus.ovf);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cyc%0d: done=%b busy=%b expected 0 0", i, bus.done, bus.busy);
            end
        end
        reset = 1'b1;
        prev_dout = 8'h00;
        prev_ovf = 1'b0;
        run_op(8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 1000; n++)
            run_op(8'($urandom_range(255)), 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.din = 8'h00;
        bus.mode = 1'b0;
        test_reset;
        test_ones;
        test_boundary;
        test_back_to_back;
        test_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
